// File: rtl/tart_visibility_correlator.sv
// TART visibility correlator: CORES time-multiplexed cores accumulate 1-bit complex
// correlation counts for every antenna pair over a frame, then stream them out in pair order.
module tart_visibility_correlator #(
    parameter int WIDTH   = 32,
    parameter int CORES   = 18,
    parameter int TRATE   = 30,
    parameter int TBITS   = 5,
    parameter int WORDS   = 32,
    parameter int COUNT   = 15,
    parameter int ADDR    = 4,
    parameter int ACCUM   = 36,
    parameter int SUMBITS = 6
) (
    input  logic             vis_clock,
    input  logic             reset_ni,
    input  logic             enable_i,
    output logic             vis_start_o,
    output logic             vis_frame_o,
    input  logic [WIDTH-1:0] sig_idata_i,
    input  logic [WIDTH-1:0] sig_qdata_i,
    input  logic             sig_valid_i,
    output logic             sig_ready_o,
    input  logic             sig_last_i,
    output logic [ACCUM-1:0] bus_revis_o,
    output logic [ACCUM-1:0] bus_imvis_o,
    output logic             bus_valid_o,
    input  logic             bus_ready_i,
    output logic             bus_last_o
);

    localparam int NP    = WIDTH * (WIDTH - 1) / 2;
    localparam int CBITS = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int SBITS = (COUNT > 1) ? $clog2(COUNT) : 1;

    localparam logic [SBITS-1:0] SAMPLE_LAST   = SBITS'(COUNT - 1);
    localparam logic [ADDR-1:0]  BLOCK_LAST    = '1;
    localparam logic [TBITS-1:0] SLOT_LAST     = TBITS'(TRATE - 1);
    localparam logic [TBITS-1:0] OUT_SLOT_LAST = TBITS'((NP - 1) % TRATE);
    localparam logic [CBITS-1:0] OUT_CORE_LAST = CBITS'((NP - 1) / TRATE);

    // Lexicographic pair index -> antenna indices; unused pair slots map to antenna 0.
    function automatic int pair_a(input int p);
        int rem;
        rem    = p;
        pair_a = 0;
        for (int a = 0; a < WIDTH - 1; a++) begin
            if (rem >= 0 && rem < WIDTH - 1 - a) pair_a = a;
            rem = rem - (WIDTH - 1 - a);
        end
    endfunction

    function automatic int pair_b(input int p);
        int rem;
        rem    = p;
        pair_b = 0;
        for (int a = 0; a < WIDTH - 1; a++) begin
            if (rem >= 0 && rem < WIDTH - 1 - a) pair_b = a + 1 + rem;
            rem = rem - (WIDTH - 1 - a);
        end
    endfunction

    if (CORES * TRATE < NP) begin : g_bad_pairs
        $error("CORES*TRATE cannot cover all antenna pairs");
    end
    if (2 * COUNT >= (1 << SUMBITS)) begin : g_bad_sumbits
        $error("SUMBITS too narrow for COUNT");
    end
    if ((1 << TBITS) < TRATE || WORDS < TRATE || TRATE < 2) begin : g_bad_trate
        $error("TRATE inconsistent with TBITS/WORDS");
    end

    logic [WIDTH-1:0] idata_reg, qdata_reg;
    logic             busy_reg;
    logic [TBITS-1:0] slot_reg;
    logic             s1_valid_reg;
    logic [TBITS-1:0] s1_slot_reg;
    logic             blk_first_reg, blk_last_reg, frm_first_reg, frm_last_reg;
    logic [SBITS-1:0] sample_cnt_reg;
    logic [ADDR-1:0]  block_cnt_reg;
    logic             flush_reg, stream_reg, bus_valid_reg, start_reg, frame_reg;
    logic [TBITS-1:0] out_slot_reg, out_slot_next, acc_raddr;
    logic [CBITS-1:0] out_core_reg, out_core_next;
    logic             accept, blk_end_now, frm_end_now, stream_go, adv, out_end;
    logic [2*ACCUM-1:0] acc_rd_core [CORES];

    assign sig_ready_o = enable_i && reset_ni && !busy_reg && !flush_reg && !stream_reg;
    assign accept      = sig_valid_i && sig_ready_o;
    assign blk_end_now = sig_last_i || (sample_cnt_reg == SAMPLE_LAST);
    assign frm_end_now = sig_last_i || (sample_cnt_reg == SAMPLE_LAST && block_cnt_reg == BLOCK_LAST);
    assign stream_go   = s1_valid_reg && frm_last_reg && (s1_slot_reg == SLOT_LAST);
    assign adv         = bus_valid_reg && bus_ready_i;
    assign out_end     = (out_core_reg == OUT_CORE_LAST) && (out_slot_reg == OUT_SLOT_LAST);

    always_comb begin
        out_slot_next = out_slot_reg + 1'b1;
        out_core_next = out_core_reg;
        if (out_slot_reg == SLOT_LAST) begin
            out_slot_next = '0;
            out_core_next = out_core_reg + 1'b1;
        end
    end

    // Accumulator read port is shared: look-ahead beat address while streaming, slot address while computing.
    always_comb begin
        acc_raddr = '0;
        if (stream_reg)    acc_raddr = adv ? out_slot_next : out_slot_reg;
        else if (busy_reg) acc_raddr = slot_reg;
    end

    always_ff @(posedge vis_clock) begin
        if (accept) begin
            idata_reg <= sig_idata_i;
            qdata_reg <= sig_qdata_i;
        end
    end

    always_ff @(posedge vis_clock) begin
        if (!reset_ni) begin
            busy_reg       <= 1'b0;
            slot_reg       <= '0;
            s1_valid_reg   <= 1'b0;
            s1_slot_reg    <= '0;
            blk_first_reg  <= 1'b0;
            blk_last_reg   <= 1'b0;
            frm_first_reg  <= 1'b0;
            frm_last_reg   <= 1'b0;
            sample_cnt_reg <= '0;
            block_cnt_reg  <= '0;
            flush_reg      <= 1'b0;
            stream_reg     <= 1'b0;
            bus_valid_reg  <= 1'b0;
            start_reg      <= 1'b0;
            frame_reg      <= 1'b0;
            out_slot_reg   <= '0;
            out_core_reg   <= '0;
        end else begin
            start_reg    <= accept && sample_cnt_reg == '0 && block_cnt_reg == '0;
            frame_reg    <= stream_go;
            s1_valid_reg <= busy_reg;
            s1_slot_reg  <= slot_reg;
            if (accept) begin
                busy_reg      <= 1'b1;
                slot_reg      <= '0;
                blk_first_reg <= (sample_cnt_reg == '0);
                blk_last_reg  <= blk_end_now;
                frm_first_reg <= (block_cnt_reg == '0);
                frm_last_reg  <= frm_end_now;
                if (frm_end_now) begin
                    sample_cnt_reg <= '0;
                    block_cnt_reg  <= '0;
                    flush_reg      <= 1'b1;
                end else if (blk_end_now) begin
                    sample_cnt_reg <= '0;
                    block_cnt_reg  <= block_cnt_reg + 1'b1;
                end else begin
                    sample_cnt_reg <= sample_cnt_reg + 1'b1;
                end
            end else if (busy_reg) begin
                slot_reg <= slot_reg + 1'b1;
                if (slot_reg == SLOT_LAST) busy_reg <= 1'b0;
            end
            if (stream_go) begin
                flush_reg     <= 1'b0;
                stream_reg    <= 1'b1;
                bus_valid_reg <= 1'b1;
            end
            if (adv) begin
                if (out_end) begin
                    stream_reg    <= 1'b0;
                    bus_valid_reg <= 1'b0;
                    out_slot_reg  <= '0;
                    out_core_reg  <= '0;
                end else begin
                    out_slot_reg <= out_slot_next;
                    out_core_reg <= out_core_next;
                end
            end
        end
    end

    genvar gi, gs;
    for (gi = 0; gi < CORES; gi++) begin : g_core
        logic [TRATE-1:0]     ia_v, ib_v, qa_v, qb_v;
        logic [2*SUMBITS-1:0] part_mem [WORDS];
        logic [2*ACCUM-1:0]   acc_mem [WORDS];
        logic [2*SUMBITS-1:0] part_rd_reg;
        logic [2*ACCUM-1:0]   acc_rd_reg;
        logic                 ia, ib, qa, qb;
        logic [1:0]           inc_re, inc_im;
        logic [SUMBITS-1:0]   part_re_next, part_im_next;
        logic [ACCUM-1:0]     acc_re_next, acc_im_next;

        for (gs = 0; gs < TRATE; gs++) begin : g_slot
            localparam int PA = pair_a(gi * TRATE + gs);
            localparam int PB = pair_b(gi * TRATE + gs);
            assign ia_v[gs] = idata_reg[PA];
            assign ib_v[gs] = idata_reg[PB];
            assign qa_v[gs] = qdata_reg[PA];
            assign qb_v[gs] = qdata_reg[PB];
        end

        // First sample of a block / first block of a frame ignore whatever the memories hold.
        always_comb begin
            ia = ia_v[s1_slot_reg];
            ib = ib_v[s1_slot_reg];
            qa = qa_v[s1_slot_reg];
            qb = qb_v[s1_slot_reg];
            inc_re = {1'b0, ia == ib} + {1'b0, qa == qb};
            inc_im = {1'b0, qa == ib} + {1'b0, ia != qb};
            part_re_next = (blk_first_reg ? '0 : part_rd_reg[2*SUMBITS-1:SUMBITS]) + SUMBITS'(inc_re);
            part_im_next = (blk_first_reg ? '0 : part_rd_reg[SUMBITS-1:0]) + SUMBITS'(inc_im);
            acc_re_next  = (frm_first_reg ? '0 : acc_rd_reg[2*ACCUM-1:ACCUM]) + ACCUM'(part_re_next);
            acc_im_next  = (frm_first_reg ? '0 : acc_rd_reg[ACCUM-1:0]) + ACCUM'(part_im_next);
        end

        always_ff @(posedge vis_clock) begin
            part_rd_reg <= part_mem[slot_reg];
            if (s1_valid_reg && !blk_last_reg) part_mem[s1_slot_reg] <= {part_re_next, part_im_next};
        end

        always_ff @(posedge vis_clock) begin
            acc_rd_reg <= acc_mem[acc_raddr];
            if (s1_valid_reg && blk_last_reg) acc_mem[s1_slot_reg] <= {acc_re_next, acc_im_next};
        end

        assign acc_rd_core[gi] = acc_rd_reg;
    end

    assign bus_revis_o = bus_valid_reg ? acc_rd_core[out_core_reg][2*ACCUM-1:ACCUM] : '0;
    assign bus_imvis_o = bus_valid_reg ? acc_rd_core[out_core_reg][ACCUM-1:0] : '0;
    assign bus_valid_o = bus_valid_reg;
    assign bus_last_o  = bus_valid_reg && out_end;
    assign vis_start_o = start_reg;
    assign vis_frame_o = frame_reg;

endmodule

// File: tb/tb_tart_visibility_correlator.sv
// Bench for tart_visibility_correlator: directed frames with random data, checked against
// a pair-by-pair reference computed from stored samples.
module tb_tart_visibility_correlator;

    localparam int W   = 32;
    localparam int NP  = W * (W - 1) / 2;
    localparam int ACC = 36;

    logic           clk = 1'b0;
    logic           reset_ni, enable_i;
    logic           vis_start_o, vis_frame_o;
    logic [W-1:0]   sig_idata_i, sig_qdata_i;
    logic           sig_valid_i, sig_ready_o, sig_last_i;
    logic [ACC-1:0] bus_revis_o, bus_imvis_o;
    logic           bus_valid_o, bus_ready_i, bus_last_o;

    tart_visibility_correlator dut (
        .vis_clock  (clk),
        .reset_ni   (reset_ni),
        .enable_i   (enable_i),
        .vis_start_o(vis_start_o),
        .vis_frame_o(vis_frame_o),
        .sig_idata_i(sig_idata_i),
        .sig_qdata_i(sig_qdata_i),
        .sig_valid_i(sig_valid_i),
        .sig_ready_o(sig_ready_o),
        .sig_last_i (sig_last_i),
        .bus_revis_o(bus_revis_o),
        .bus_imvis_o(bus_imvis_o),
        .bus_valid_o(bus_valid_o),
        .bus_ready_i(bus_ready_i),
        .bus_last_o (bus_last_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cnt = 0;
    int frame_cnt = 0;
    int prev_acc = 0;
    bit have_prev = 1'b0;

    logic [W-1:0] si[$];
    logic [W-1:0] sq[$];
    logic [63:0]  exp_re[NP];
    logic [63:0]  exp_im[NP];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vis_start_o === 1'b1) start_cnt <= start_cnt + 1;
        if (vis_frame_o === 1'b1) frame_cnt <= frame_cnt + 1;
    end

    task automatic check(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s[%0d]: got %0d expected %0d", tag, idx, obs, expv);
        end
    endtask

    // Reference: sum the increment rules over every stored sample for each pair a<b in order.
    function automatic void build_model();
        int p = 0;
        for (int a = 0; a < W - 1; a++) begin
            for (int b = a + 1; b < W; b++) begin
                longint re = 0;
                longint im = 0;
                for (int s = 0; s < si.size(); s++) begin
                    re += longint'(si[s][a] == si[s][b]) + longint'(sq[s][a] == sq[s][b]);
                    im += longint'(sq[s][a] == si[s][b]) + longint'(si[s][a] != sq[s][b]);
                end
                exp_re[p] = 64'(re);
                exp_im[p] = 64'(im);
                p++;
            end
        end
    endfunction

    task automatic send_sample(input logic [W-1:0] i, input logic [W-1:0] q, input logic last,
                               input bit chk_spacing);
        int n = 0;
        sig_idata_i = i;
        sig_qdata_i = q;
        sig_last_i  = last;
        sig_valid_i = 1'b1;
        @(negedge clk);
        while (sig_ready_o !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("accept_wait", 0, 64'(n < 200), 64'(1));
        if (chk_spacing && have_prev) check("spacing", si.size(), 64'(cyc - prev_acc), 64'(31));
        prev_acc  = cyc;
        have_prev = 1'b1;
        si.push_back(i);
        sq.push_back(q);
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input bit rand_ready);
        int beat = 0;
        int n = 0;
        int stab_bad = 0;
        int ready_bad = 0;
        bit stalled = 1'b0;
        bit first = 1'b1;
        logic [ACC-1:0] hold_re = '0;
        logic [ACC-1:0] hold_im = '0;
        while (beat < NP && n < 20000) begin
            bus_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus_valid_o === 1'b1) begin
                if (first) begin
                    check("frame_with_first_beat", 0, 64'(vis_frame_o), 64'(1));
                    first = 1'b0;
                end
                if (sig_ready_o !== 1'b0) ready_bad++;
                if (stalled && (bus_revis_o !== hold_re || bus_imvis_o !== hold_im)) stab_bad++;
                if (bus_ready_i) begin
                    check("re", beat, 64'(bus_revis_o), exp_re[beat]);
                    check("im", beat, 64'(bus_imvis_o), exp_im[beat]);
                    check("last", beat, 64'(bus_last_o), 64'(beat == NP - 1));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_re = bus_revis_o;
                    hold_im = bus_imvis_o;
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus_ready_i = 1'b1;
        check("beats", 0, 64'(beat), 64'(NP));
        check("stall_stable", 0, 64'(stab_bad), 64'(0));
        check("ready_low_stream", 0, 64'(ready_bad), 64'(0));
        @(negedge clk);
        check("valid_after_stream", 0, 64'(bus_valid_o), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // mode: 0 I=Q=1, 1 I=antenna-0 one-hot Q=0, 2 I=1 Q=0, 3 random
    task automatic run_frame(input int nsamp, input int mode, input bit use_last,
                             input bit rand_ready, input int en_gap_at);
        int s0 = start_cnt;
        int f0 = frame_cnt;
        si.delete();
        sq.delete();
        have_prev = 1'b0;
        for (int k = 0; k < nsamp; k++) begin
            logic [W-1:0] i, q;
            bit spacing = 1'b1;
            case (mode)
                0:       begin i = '1;              q = '1; end
                1:       begin i = W'(1);           q = '0; end
                2:       begin i = '1;              q = '0; end
                default: begin i = W'($urandom()); q = W'($urandom()); end
            endcase
            if (k == en_gap_at) begin
                int seen = 0;
                enable_i = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (sig_ready_o !== 1'b0) seen++;
                end
                @(posedge clk);
                #1;
                check("ready_while_disabled", k, 64'(seen), 64'(0));
                enable_i = 1'b1;
                spacing  = 1'b0;
            end
            send_sample(i, q, use_last && (k == nsamp - 1), spacing);
        end
        sig_valid_i = 1'b0;
        sig_last_i  = 1'b0;
        build_model();
        collect(rand_ready);
        check("start_pulses", 0, 64'(start_cnt - s0), 64'(1));
        check("frame_pulses", 0, 64'(frame_cnt - f0), 64'(1));
    endtask

    initial begin
        reset_ni    = 1'b0;
        enable_i    = 1'b1;
        sig_idata_i = '0;
        sig_qdata_i = '0;
        sig_valid_i = 1'b0;
        sig_last_i  = 1'b0;
        bus_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", 0, 64'(sig_ready_o), 64'(0));
        check("rst_valid", 0, 64'(bus_valid_o), 64'(0));
        check("rst_last", 0, 64'(bus_last_o), 64'(0));
        check("rst_start", 0, 64'(vis_start_o), 64'(0));
        check("rst_frame", 0, 64'(vis_frame_o), 64'(0));
        check("rst_re", 0, 64'(bus_revis_o), 64'(0));
        check("rst_im", 0, 64'(bus_imvis_o), 64'(0));
        @(posedge clk);
        #1;
        reset_ni = 1'b1;

        run_frame(240, 0, 1'b0, 1'b0, -1);
        run_frame(240, 1, 1'b0, 1'b0, -1);
        run_frame(240, 3, 1'b0, 1'b1, -1);
        run_frame(10, 2, 1'b1, 1'b0, -1);
        run_frame(37, 3, 1'b1, 1'b1, 20);

        // Abandon a frame mid-way with a one-cycle reset.
        si.delete();
        sq.delete();
        have_prev = 1'b0;
        for (int k = 0; k < 100; k++) send_sample(W'($urandom()), W'($urandom()), 1'b0, 1'b1);
        sig_valid_i = 1'b0;
        reset_ni = 1'b0;
        @(negedge clk);
        check("midrst_ready", 0, 64'(sig_ready_o), 64'(0));
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        @(negedge clk);
        check("midrst_valid", 0, 64'(bus_valid_o), 64'(0));
        check("midrst_re", 0, 64'(bus_revis_o), 64'(0));
        check("midrst_start", 0, 64'(vis_start_o), 64'(0));
        check("midrst_frame", 0, 64'(vis_frame_o), 64'(0));
        @(posedge clk);
        #1;
        run_frame(240, 0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
